// File: rtl/weight_sparse_pack.sv
// Sparse weight packer: turns a {sparse, weight} element stream into column-indexed FIFO entries.
// Latency: accept -> out_valid one cycle later when the FIFO was empty; entries leave in push order.
// Backpressure: in_ready drops while the FIFO holds DEPTH entries; out_data is held until out_ready.
// Optional consistency checker enabled by macro WEIGHT_SPARSE_PACK_CHK_EN (err tied low otherwise).
module weight_sparse_pack #(
  parameter int DEPTH = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        sys_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic [15:0] col_cnt,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // FIFO storage and bookkeeping
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Column position of the next accepted element
  logic [2:0]    idx;

  // Input decode
  logic          sparse;
  logic [7:0]    weight;
  logic          accept;
  logic          col_end;
  logic          push;
  logic          pop;
  logic          full;
  logic [11:0]   push_dat;

  assign sparse  = data_in[8];
  assign weight  = data_in[7:0];
  assign full    = (count == FULL_CNT);
  assign in_ready = !full;
  assign accept  = in_valid && in_ready && sys_en;
  assign col_end = (idx == 3'd7);

  // A sparse element mid-column is dropped; the column end always emits one entry,
  // carrying a zero weight when it is itself sparse so the consumer sees a terminator.
  assign push     = accept && (!sparse || col_end);
  assign push_dat = {col_end, idx, (sparse ? 8'h00 : weight)};

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // Empty FIFO presents zero so the output is clean straight out of reset.
  assign out_data = out_valid ? mem[rd_ptr] : 12'h000;

  // Element index and completed-column counter advance only on accepts
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      idx     <= 3'd0;
      col_cnt <= 16'h0000;
    end else if (accept) begin
      idx <= idx + 3'd1;
      if (col_end) begin
        col_cnt <= col_cnt + 16'h0001;
      end
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers and occupancy; a push and pop in the same cycle leave count unchanged
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WEIGHT_SPARSE_PACK_CHK_EN
  // Sticky flag: the encoder's sparse bit must agree with the weight being zero
  logic mismatch;
  assign mismatch = sparse != (weight == 8'h00);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && mismatch) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
